// File: rtl/boot_mode_ctrl.sv
// boot_mode_ctrl: boot / UART programming mode controller.
//
// Holds the CPU in reset for a settle period after reset or after a programming
// session, runs the CPU, and switches to UART programming mode when the
// programming button is held long enough. Counts words written by the loader.
//
// Optional feature: define BOOT_TIMEOUT_EN to add a programming idle timeout
// that moves to a sticky error state (err_o=1) when the loader goes quiet.
//
// Ports:
//   clock       - single clock, rising edge
//   rst         - asynchronous active-high reset
//   start_pg    - raw programming button (asynchronous)
//   upg_wen_i   - UART loader write strobe (asynchronous)
//   upg_done_i  - UART loader done level (asynchronous)
//   upg_rst_o   - UART loader reset (1 = held in reset), registered
//   cpu_rst_o   - CPU core reset (1 = held in reset), registered
//   state_o     - current state encoding
//   word_cnt_o  - words received in the current or last session
//   err_o       - programming timeout flag (sticky until next session)

module boot_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 100000,
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned TIMEOUT_CYC  = 50000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start_pg,
    input  logic        upg_wen_i,
    input  logic        upg_done_i,
    output logic        upg_rst_o,
    output logic        cpu_rst_o,
    output logic [2:0]  state_o,
    output logic [15:0] word_cnt_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StSettle   = 3'd0,
        StRun      = 3'd1,
        StDebounce = 3'd2,
        StProg     = 3'd3,
        StErr      = 3'd4
    } state_e;

    localparam logic [31:0] SettleLoad   = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] DebounceLoad = 32'(DEBOUNCE_CYC - 1);

    // Input synchronizers plus one extra flop per strobe for edge detection.
    logic [1:0] start_sync_q, wen_sync_q, done_sync_q;
    logic       wen_prev_q, done_prev_q;
    logic       start_s, wen_rise, done_rise;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            start_sync_q <= 2'b00;
            wen_sync_q   <= 2'b00;
            done_sync_q  <= 2'b00;
            wen_prev_q   <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[0], start_pg};
            wen_sync_q   <= {wen_sync_q[0], upg_wen_i};
            done_sync_q  <= {done_sync_q[0], upg_done_i};
            wen_prev_q   <= wen_sync_q[1];
            done_prev_q  <= done_sync_q[1];
        end
    end

    assign start_s   = start_sync_q[1];
    // done_prev tracks the level in every state, so a done already high on
    // PROG entry produces no edge until it falls and rises again.
    assign wen_rise  = wen_sync_q[1] & ~wen_prev_q;
    assign done_rise = done_sync_q[1] & ~done_prev_q;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] word_q, word_d;
    logic        from_err_q, from_err_d;   // DEBOUNCE was entered from ERR
    logic        cpu_rst_q, cpu_rst_d;
    logic        upg_rst_q, upg_rst_d;

`ifdef BOOT_TIMEOUT_EN
    localparam logic [31:0] TimeoutLoad = 32'(TIMEOUT_CYC - 1);
    logic [31:0] idle_q, idle_d;
    logic        err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        from_err_d = from_err_q;
`ifdef BOOT_TIMEOUT_EN
        idle_d     = idle_q;
        err_d      = err_q;
`endif
        case (state_q)
            StSettle: begin
                if (cnt_q == 32'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StRun: begin
                if (start_s) begin
                    state_d    = StDebounce;
                    cnt_d      = DebounceLoad;
                    from_err_d = 1'b0;
                end
            end
            StDebounce: begin
                if (!start_s) begin
                    state_d = from_err_q ? StErr : StRun;
                end else if (cnt_q == 32'd0) begin
                    state_d = StProg;
                    word_d  = 16'd0;
`ifdef BOOT_TIMEOUT_EN
                    idle_d  = TimeoutLoad;
                    err_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StProg: begin
                // A write edge counts even when done arrives in the same cycle.
                if (wen_rise && (word_q != 16'hFFFF)) begin
                    word_d = word_q + 16'd1;
                end
                if (done_rise) begin
                    state_d = StSettle;
                    cnt_d   = SettleLoad;
`ifdef BOOT_TIMEOUT_EN
                end else if (wen_rise) begin
                    idle_d = TimeoutLoad;
                end else if (idle_q == 32'd0) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    idle_d = idle_q - 32'd1;
`endif
                end
            end
`ifdef BOOT_TIMEOUT_EN
            StErr: begin
                if (start_s) begin
                    state_d    = StDebounce;
                    cnt_d      = DebounceLoad;
                    from_err_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = StSettle;
                cnt_d   = SettleLoad;
            end
        endcase

        // Outputs follow the next state so they are registered alongside it.
        cpu_rst_d = 1'b1;
        upg_rst_d = 1'b1;
        case (state_d)
            StRun:      cpu_rst_d = 1'b0;
            StDebounce: cpu_rst_d = from_err_d;
            StProg:     upg_rst_d = 1'b0;
            default: begin
                cpu_rst_d = 1'b1;
                upg_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= StSettle;
            cnt_q      <= SettleLoad;
            word_q     <= 16'd0;
            from_err_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            upg_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            from_err_q <= from_err_d;
            cpu_rst_q  <= cpu_rst_d;
            upg_rst_q  <= upg_rst_d;
        end
    end

`ifdef BOOT_TIMEOUT_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            idle_q <= TimeoutLoad;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign state_o    = state_q;
    assign word_cnt_o = word_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign upg_rst_o  = upg_rst_q;

endmodule

// File: tb/tb_boot_mode_ctrl.sv
module tb_boot_mode_ctrl;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        start_pg = 1'b0;
    logic        upg_wen_i = 1'b0;
    logic        upg_done_i = 1'b0;
    logic        upg_rst_o, cpu_rst_o, err_o;
    logic [2:0]  state_o;
    logic [15:0] word_cnt_o;

    int total = 0;
    int bad = 0;

    boot_mode_ctrl #(
        .DEBOUNCE_CYC(4),
        .SETTLE_CYC  (3),
        .TIMEOUT_CYC (20)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .start_pg  (start_pg),
        .upg_wen_i (upg_wen_i),
        .upg_done_i(upg_done_i),
        .upg_rst_o (upg_rst_o),
        .cpu_rst_o (cpu_rst_o),
        .state_o   (state_o),
        .word_cnt_o(word_cnt_o),
        .err_o     (err_o)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (state_o === s) ok = 1'b1;
        end
    endtask

    task automatic enter_prog(output bit ok);
        start_pg = 1'b1;
        wait_state(3'd3, 20, ok);
        start_pg = 1'b0;
    endtask

    task automatic pulse_wen();
        upg_wen_i = 1'b1;
        tick();
        tick();
        upg_wen_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_o); end
        total++; if (cpu_rst_o !== 1'b1) begin bad++; $display("FAIL rst_cpu: got %b want 1", cpu_rst_o); end
        total++; if (upg_rst_o !== 1'b1) begin bad++; $display("FAIL rst_upg: got %b want 1", upg_rst_o); end
        total++; if (word_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_word: got %0d want 0", word_cnt_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_o); end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (state_o !== 3'd0 || cpu_rst_o !== 1'b1) begin
                bad++; $display("FAIL settle_hold: cyc %0d state %0d cpu %b want 0/1", i, state_o, cpu_rst_o);
            end
        end
        tick();
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL settle_to_run: got %0d want 1", state_o); end
        total++; if (cpu_rst_o !== 1'b0 || upg_rst_o !== 1'b1) begin
            bad++; $display("FAIL run_outputs: cpu %b upg %b want 0/1", cpu_rst_o, upg_rst_o);
        end
    endtask

    task automatic test_debounce_abort();
        bit ok;
        start_pg = 1'b1;
        tick();
        tick();
        start_pg = 1'b0;
        wait_state(3'd2, 5, ok);
        total++; if (!ok) begin bad++; $display("FAIL deb_enter: state %0d want 2", state_o); end
        total++; if (upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b0) begin
            bad++; $display("FAIL deb_outputs: cpu %b upg %b want 0/1", cpu_rst_o, upg_rst_o);
        end
        wait_state(3'd1, 5, ok);
        total++; if (!ok) begin bad++; $display("FAIL deb_abort: state %0d want 1", state_o); end
        total++; if (upg_rst_o !== 1'b1) begin bad++; $display("FAIL deb_abort_upg: got %b want 1", upg_rst_o); end
    endtask

    task automatic test_prog_session();
        bit ok;
        enter_prog(ok);
        total++; if (!ok) begin bad++; $display("FAIL prog_enter: state %0d want 3", state_o); end
        total++; if (upg_rst_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
            bad++; $display("FAIL prog_outputs: cpu %b upg %b want 1/0", cpu_rst_o, upg_rst_o);
        end
        for (int i = 0; i < 5; i++) pulse_wen();
        total++; if (word_cnt_o !== 16'd5) begin bad++; $display("FAIL prog_words: got %0d want 5", word_cnt_o); end
        upg_done_i = 1'b1;
        wait_state(3'd0, 6, ok);
        total++; if (!ok) begin bad++; $display("FAIL done_to_settle: state %0d want 0", state_o); end
        total++; if (upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
            bad++; $display("FAIL settle_outputs: cpu %b upg %b want 1/1", cpu_rst_o, upg_rst_o);
        end
        tick();
        tick();
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL settle_len: got %0d want 0", state_o); end
        tick();
        total++; if (state_o !== 3'd1 || cpu_rst_o !== 1'b0) begin
            bad++; $display("FAIL settle_exit: state %0d cpu %b want 1/0", state_o, cpu_rst_o);
        end
        total++; if (word_cnt_o !== 16'd5) begin bad++; $display("FAIL word_hold: got %0d want 5", word_cnt_o); end
        upg_done_i = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        enter_prog(ok);
        total++; if (!ok || word_cnt_o !== 16'd0) begin
            bad++; $display("FAIL b2b_enter: state %0d word %0d want 3/0", state_o, word_cnt_o);
        end
        pulse_wen();
        pulse_wen();
        upg_wen_i = 1'b1;
        upg_done_i = 1'b1;
        tick();
        tick();
        total++; if (state_o !== 3'd3) begin bad++; $display("FAIL b2b_early: got %0d want 3", state_o); end
        tick();
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL b2b_state: got %0d want 0", state_o); end
        total++; if (word_cnt_o !== 16'd3) begin bad++; $display("FAIL b2b_words: got %0d want 3", word_cnt_o); end
        upg_wen_i = 1'b0;
        upg_done_i = 1'b0;
        wait_state(3'd1, 6, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_run: state %0d want 1", state_o); end
    endtask

    task automatic test_done_high_entry();
        bit ok;
        upg_done_i = 1'b1;
        tick();
        tick();
        tick();
        enter_prog(ok);
        total++; if (!ok) begin bad++; $display("FAIL dhe_enter: state %0d want 3", state_o); end
        for (int i = 0; i < 5; i++) tick();
        total++; if (state_o !== 3'd3) begin bad++; $display("FAIL dhe_ignored: got %0d want 3", state_o); end
        upg_done_i = 1'b0;
        tick();
        tick();
        tick();
        upg_done_i = 1'b1;
        wait_state(3'd0, 6, ok);
        total++; if (!ok) begin bad++; $display("FAIL dhe_exit: state %0d want 0", state_o); end
        upg_done_i = 1'b0;
        wait_state(3'd1, 6, ok);
        total++; if (!ok) begin bad++; $display("FAIL dhe_run: state %0d want 1", state_o); end
    endtask

`ifdef BOOT_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        enter_prog(ok);
        total++; if (!ok) begin bad++; $display("FAIL to_enter: state %0d want 3", state_o); end
        for (int i = 0; i < 19; i++) tick();
        total++; if (state_o !== 3'd3) begin bad++; $display("FAIL to_early: got %0d want 3", state_o); end
        tick();
        total++; if (state_o !== 3'd4 || err_o !== 1'b1) begin
            bad++; $display("FAIL to_err: state %0d err %b want 4/1", state_o, err_o);
        end
        total++; if (cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1) begin
            bad++; $display("FAIL err_outputs: cpu %b upg %b want 1/1", cpu_rst_o, upg_rst_o);
        end
        start_pg = 1'b1;
        tick();
        tick();
        tick();
        total++; if (state_o !== 3'd2 || cpu_rst_o !== 1'b1) begin
            bad++; $display("FAIL err_deb: state %0d cpu %b want 2/1", state_o, cpu_rst_o);
        end
        tick();
        tick();
        tick();
        start_pg = 1'b0;
        wait_state(3'd3, 5, ok);
        total++; if (!ok || err_o !== 1'b0) begin
            bad++; $display("FAIL err_reprog: state %0d err %b want 3/0", state_o, err_o);
        end
        upg_done_i = 1'b1;
        wait_state(3'd0, 6, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_exit: state %0d want 0", state_o); end
        upg_done_i = 1'b0;
        wait_state(3'd1, 6, ok);
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        enter_prog(ok);
        total++; if (!ok) begin bad++; $display("FAIL nto_enter: state %0d want 3", state_o); end
        for (int i = 0; i < 30; i++) tick();
        total++; if (state_o !== 3'd3 || err_o !== 1'b0) begin
            bad++; $display("FAIL nto_idle: state %0d err %b want 3/0", state_o, err_o);
        end
        upg_done_i = 1'b1;
        wait_state(3'd0, 6, ok);
        total++; if (!ok) begin bad++; $display("FAIL nto_exit: state %0d want 0", state_o); end
        upg_done_i = 1'b0;
        wait_state(3'd1, 6, ok);
    endtask
`endif

    task automatic test_reset_mid_prog();
        bit ok;
        enter_prog(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmp_enter: state %0d want 3", state_o); end
        for (int i = 0; i < 7; i++) pulse_wen();
        total++; if (word_cnt_o !== 16'd7) begin bad++; $display("FAIL rmp_words: got %0d want 7", word_cnt_o); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (word_cnt_o !== 16'd0 || state_o !== 3'd0) begin
            bad++; $display("FAIL rmp_async: word %0d state %0d want 0/0", word_cnt_o, state_o);
        end
        total++; if (upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
            bad++; $display("FAIL rmp_outputs: cpu %b upg %b want 1/1", cpu_rst_o, upg_rst_o);
        end
        tick();
        rst = 1'b0;
        wait_state(3'd1, 6, ok);
        total++; if (!ok || word_cnt_o !== 16'd0) begin
            bad++; $display("FAIL rmp_recover: state %0d word %0d want 1/0", state_o, word_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_debounce_abort();
        test_prog_session();
        test_back_to_back();
        test_done_high_entry();
`ifdef BOOT_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_prog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_mode_ctrl.md
BOOT_MODE_CTRL -- requirements
Module: boot_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 100000, which is the number of cycles start_pg must stay high to enter programming.
REQ-002 SHALL have parameter SETTLE_CYC, default 16, which is the number of cycles CPU reset is held after reset or after programming completes.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000000, which is the programming idle limit (used only under BOOT_TIMEOUT_EN).
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start_pg, input, 1 bit: raw programming button, asynchronous.
REQ-007 SHALL have port upg_wen_i, input, 1 bit: UART loader write strobe, asynchronous to clock.
REQ-008 SHALL have port upg_done_i, input, 1 bit: UART loader done, level, asynchronous to clock.
REQ-009 SHALL have port upg_rst_o, output, 1 bit: UART loader reset; 1 means loader held in reset.
REQ-010 SHALL have port cpu_rst_o, output, 1 bit: CPU core reset (to fetch, decode, LED and seg drivers).
REQ-011 SHALL have port state_o, output, 3 bits: current state encoding.
REQ-012 SHALL have port word_cnt_o, output, 16 bits: words received in the current or last programming session.
REQ-013 SHALL have port err_o, output, 1 bit: programming timeout flag.

Function
REQ-014 SHALL pass start_pg, upg_wen_i and upg_done_i each through a 2-flop synchronizer; all decisions use the synchronized values (2-cycle input latency).
REQ-015 SHALL implement states SETTLE=3'd0, RUN=3'd1, DEBOUNCE=3'd2, PROG=3'd3, ERR=3'd4; state_o SHALL equal the state register.
REQ-016 SETTLE: cpu_rst_o=1, upg_rst_o=1; a down-counter runs; when it reaches 0 the block SHALL go to RUN, so SETTLE lasts exactly SETTLE_CYC cycles.
REQ-017 RUN: cpu_rst_o=0, upg_rst_o=1; synchronized start_pg=1 SHALL move to DEBOUNCE with the counter loaded to DEBOUNCE_CYC-1.
REQ-018 DEBOUNCE: outputs are as in RUN (entered from RUN) or as in ERR (entered from ERR).
REQ-019 DEBOUNCE: start_pg low on any cycle SHALL return to the originating state (RUN or ERR).
REQ-020 DEBOUNCE: counter reaching 0 with start_pg high SHALL enter PROG, clear word_cnt_o and clear err_o.
REQ-021 PROG: upg_rst_o=0, cpu_rst_o=1.
REQ-022 PROG: each rising edge of synchronized upg_wen_i SHALL increment word_cnt_o, saturating at 16'hFFFF.
REQ-023 PROG: a rising edge of synchronized upg_done_i SHALL go to SETTLE with the counter loaded to SETTLE_CYC-1.
REQ-024 A wen edge and a done edge in the same cycle SHALL both take effect: count, then SETTLE.
REQ-025 A done level already high on PROG entry SHALL be ignored until it falls and rises again.
REQ-026 word_cnt_o SHALL hold its value outside PROG until the next PROG entry.
REQ-027 upg_rst_o and cpu_rst_o SHALL be registered outputs (glitch-free); they SHALL never both be 0.

Reset
REQ-028 rst=1 SHALL immediately force state SETTLE, counter=SETTLE_CYC-1, cpu_rst_o=1, upg_rst_o=1, word_cnt_o=0, err_o=0, and all synchronizers to 0.
REQ-029 rst during PROG SHALL abort the session with no partial state retained except the reset values.

Configuration
REQ-030 With BOOT_TIMEOUT_EN defined, PROG SHALL keep an idle counter that is reloaded on PROG entry and on each wen edge.
REQ-031 With BOOT_TIMEOUT_EN defined, the idle counter expiring after TIMEOUT_CYC cycles SHALL go to ERR; a done edge in the expiry cycle wins (goes to SETTLE).
REQ-032 With BOOT_TIMEOUT_EN defined, ERR SHALL hold cpu_rst_o=1, upg_rst_o=1 and err_o=1 (sticky), and SHALL leave only through DEBOUNCE to PROG.
REQ-033 Without BOOT_TIMEOUT_EN, there SHALL be no idle counter, ERR SHALL be unreachable, and err_o SHALL be tied 0.

Verification (bench parameters DEBOUNCE_CYC=4, SETTLE_CYC=3, TIMEOUT_CYC=20)
REQ-034 Release rst -> cpu_rst_o=1 for 3 cycles, then state_o=1, cpu_rst_o=0, upg_rst_o=1.
REQ-035 start_pg high 2 cycles then low -> state_o goes 2 then back to 1; upg_rst_o stays 1.
REQ-036 start_pg held 8 cycles, then 5 wen pulses, then done -> state_o=3, upg_rst_o=0, word_cnt_o=5; 3 cycles of SETTLE, then RUN.
REQ-037 wen and done rising in the same cycle after 2 words -> word_cnt_o=3, state_o=0 next.
REQ-038 BOOT_TIMEOUT_EN, PROG with no wen for 20 cycles -> state_o=4, err_o=1; start_pg held 6 cycles -> state_o=3, err_o=0.
REQ-039 rst pulsed mid-PROG after 7 words -> word_cnt_o=0, state_o=0, upg_rst_o=1 asynchronously.
